float_reorder_buffer: RTL and testbench
=======================================

Name: float_reorder_buffer

Overview:
- Circular reorder buffer for the floating-point pipeline.
- Allocates ROB indexes at dual issue; these drive the FP register file's wlwt_* rename inputs.
- Captures dual CDB results and retires up to two entries per cycle in order; commits drive the register file's wea/wna/dataina/ROB_index_wt* ports.
- Index 0 is reserved as "no producer", so usable entries are 1..15.

Parameters:
- IDX_W, 4, ROB index width; depth = 2^IDX_W-1 = 15 entries, index 0 never allocated.
- DATA_W, 32, result data width.
- REG_W, 5, architectural FP register number width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous squash of all entries
- alloc_req_a  in  1  request slot A; lower program order
- alloc_req_b  in  1  request slot B; honoured only with alloc_req_a
- alloc_dest_a, alloc_dest_b  in  REG_W  destination FP register
- alloc_ready  out  1  at least two entries free
- alloc_idx_a, alloc_idx_b  out  IDX_W  indexes granted if the request is accepted this cycle
- cdb_valid_a, cdb_valid_b  in  1  result broadcast valid
- cdb_idx_a, cdb_idx_b  in  IDX_W  producing ROB index
- cdb_data_a, cdb_data_b  in  DATA_W  result value
- qry_idx_a, qry_idx_b  in  IDX_W  operand lookup index
- qry_hit_a, qry_hit_b  out  1  entry has a result (stored or same-cycle CDB)
- qry_data_a, qry_data_b  out  DATA_W  that result; 0 when no hit
- cmt_we_a, cmt_we_b  out  1  retire head / head+1 this cycle
- cmt_wn_a, cmt_wn_b  out  REG_W  destination register of the retiring entry
- cmt_idx_a, cmt_idx_b  out  IDX_W  index of the retiring entry
- cmt_data_a, cmt_data_b  out  DATA_W  value of the retiring entry
- count  out  IDX_W  occupied entries, 0..15
- empty  out  1  count==0

Behaviour:
Per-entry state:
- busy, done, dest, data.
- head and tail pointers in 1..15; increment wraps 15->1, never to 0.

Reset (async) and flush (sync):
- All busy/done cleared; head=tail=1; count=0.
- Resulting outputs: alloc_idx_a=1, alloc_idx_b=2, alloc_ready=1, cmt_we_a/b=0, empty=1, qry_hit=0.
- flush overrides alloc, CDB and commit in its cycle; cmt_we_* are forced 0 while flush=1.

Allocation:
- alloc_idx_a = tail; alloc_idx_b = tail+1 (wrapped). Both are combinational.
- alloc_ready = (count <= 13). It gives no credit for a same-cycle commit.
- A request is accepted when alloc_ready && alloc_req_a. On acceptance, at the edge: entry set busy=1, done=0, dest stored.
- Tail advances by 1 or 2.
- alloc_req_b without alloc_req_a is ignored.

Writeback:
- On cdb_valid with busy[idx] && idx!=0: data written and done=1 at the edge.
- A CDB to a non-busy index or to index 0 is dropped.
- If both CDB ports target the same index, port B wins.

Query:
- qry_hit = busy[idx] && (done[idx] || same-cycle CDB match).
- CDB bypass has priority, B over A, then stored data.
- idx 0 gives hit=0, data=0.

Commit:
- Combinational from head.
- cmt_we_a = busy[head] && done[head].
- cmt_we_b = cmt_we_a && busy[head+1] && done[head+1].
- Retiring entries clear busy at the same edge; head advances by the commit count.
- A result written at edge N can commit at edge N+1 at the earliest; there is no CDB-to-commit bypass.
- dest 0 still retires; the register file discards writes to register 0.

Count and simultaneous events:
- count_next = count + allocs − commits.
- Simultaneous alloc, commit and wrap are all legal.
- An alloc into a slot freed at the same edge is impossible, because alloc_ready is checked against the current count.

Decomposition:
- Package float_rob_pkg: IDX_W, ROB_DEPTH=15, NULL_IDX=0, REG_W, DATA_W, function rob_next(idx) implementing the 15->1 wrap.
- No sub-module. Entry state is plain arrays in one module.

Test Plan:
- Reset, then allocate pairs with dests f1..f14 → indexes 1..14 granted in order; alloc_ready drops at count=14; count=14.
- CDB idx 2 then idx 1, one per cycle → no commit until idx 1 is done; the following cycle cmt_we_a=cmt_we_b=1 with cmt_idx 1,2 and the correct data/wn; count decreases by 2.
- Fill to 14, retire 4, allocate 4 → tail wraps 15→1 (index 0 never granted); entries after the wrap commit with correct indexes.
- Same-cycle cdb_valid_a idx 5 data 0x3F800000 with qry_idx_a=5 → qry_hit_a=1, qry_data_a=0x3F800000 that cycle; cmt_we for idx 5 is not asserted before the next edge.
- CDB to a non-busy idx 9, and CDB to idx 0 → no state change, qry_hit=0.
- Assert flush with 6 entries pending, and separately rst_n low mid-operation → count=0, empty=1, alloc_idx_a=1, cmt_we=0; the next allocation is granted idx 1.

Source files
------------

// File: rtl/float_rob_pkg.sv
// Shared constants, index type and pointer-wrap helper for the FP reorder buffer.
package float_rob_pkg;

    localparam int unsigned IDX_W     = 4;
    localparam int unsigned ROB_DEPTH = (1 << IDX_W) - 1;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned DATA_W    = 32;

    typedef logic [IDX_W-1:0] rob_idx_t;

    // Index 0 means "no producer" in the rename table, so it is never allocated.
    localparam rob_idx_t NULL_IDX = '0;

    // Advance a ROB pointer, skipping the reserved index 0 (15 -> 1).
    function automatic rob_idx_t rob_next(input rob_idx_t idx);
        return (idx == rob_idx_t'(ROB_DEPTH)) ? rob_idx_t'(1) : idx + rob_idx_t'(1);
    endfunction

endpackage

// File: rtl/float_reorder_buffer.sv
// Circular reorder buffer for the FP pipeline: dual allocate, dual CDB capture,
// operand lookup with same-cycle bypass, and in-order retirement of up to two entries.
module float_reorder_buffer
    import float_rob_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alloc_req_a,
    input  logic              alloc_req_b,
    input  logic [REG_W-1:0]  alloc_dest_a,
    input  logic [REG_W-1:0]  alloc_dest_b,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx_a,
    output logic [IDX_W-1:0]  alloc_idx_b,
    input  logic              cdb_valid_a,
    input  logic              cdb_valid_b,
    input  logic [IDX_W-1:0]  cdb_idx_a,
    input  logic [IDX_W-1:0]  cdb_idx_b,
    input  logic [DATA_W-1:0] cdb_data_a,
    input  logic [DATA_W-1:0] cdb_data_b,
    input  logic [IDX_W-1:0]  qry_idx_a,
    input  logic [IDX_W-1:0]  qry_idx_b,
    output logic              qry_hit_a,
    output logic              qry_hit_b,
    output logic [DATA_W-1:0] qry_data_a,
    output logic [DATA_W-1:0] qry_data_b,
    output logic              cmt_we_a,
    output logic              cmt_we_b,
    output logic [REG_W-1:0]  cmt_wn_a,
    output logic [REG_W-1:0]  cmt_wn_b,
    output logic [IDX_W-1:0]  cmt_idx_a,
    output logic [IDX_W-1:0]  cmt_idx_b,
    output logic [DATA_W-1:0] cmt_data_a,
    output logic [DATA_W-1:0] cmt_data_b,
    output logic [IDX_W-1:0]  count,
    output logic              empty
);

    // Bit/slot 0 exists so entries can be indexed directly by ROB index; it stays idle.
    logic [ROB_DEPTH:0] busy_q, busy_d;
    logic [ROB_DEPTH:0] done_q, done_d;
    logic [REG_W-1:0]   dest_q [ROB_DEPTH+1];
    logic [DATA_W-1:0]  data_q [ROB_DEPTH+1];

    rob_idx_t head_q, head_d;
    rob_idx_t tail_q, tail_d;
    rob_idx_t count_q, count_d;
    rob_idx_t head_nx;

    logic alloc_fire_a, alloc_fire_b;
    logic cdb_ok_a, cdb_ok_b;

    assign head_nx     = rob_next(head_q);
    assign alloc_idx_a = tail_q;
    assign alloc_idx_b = rob_next(tail_q);

    // Readiness looks only at current occupancy; a same-cycle retire earns no credit,
    // which guarantees an allocation never lands in a slot being freed at this edge.
    assign alloc_ready  = (count_q <= rob_idx_t'(ROB_DEPTH - 2));
    assign alloc_fire_a = alloc_ready && alloc_req_a && !flush;
    assign alloc_fire_b = alloc_fire_a && alloc_req_b;

    // Results for idle slots or the null index are stale broadcasts and are dropped.
    assign cdb_ok_a = !flush && cdb_valid_a && (cdb_idx_a != NULL_IDX) && busy_q[cdb_idx_a];
    assign cdb_ok_b = !flush && cdb_valid_b && (cdb_idx_b != NULL_IDX) && busy_q[cdb_idx_b];

    // Retirement reads only registered done bits, so a result needs one edge before it commits.
    assign cmt_we_a   = !flush && busy_q[head_q] && done_q[head_q];
    assign cmt_we_b   = cmt_we_a && busy_q[head_nx] && done_q[head_nx];
    assign cmt_idx_a  = head_q;
    assign cmt_idx_b  = head_nx;
    assign cmt_wn_a   = dest_q[head_q];
    assign cmt_wn_b   = dest_q[head_nx];
    assign cmt_data_a = data_q[head_q];
    assign cmt_data_b = data_q[head_nx];

    assign count = count_q;
    assign empty = (count_q == '0);

    // Next-state for entry flags and pointers: capture, then retire, then allocate; flush wins.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        busy_d  = busy_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + rob_idx_t'(alloc_fire_a) + rob_idx_t'(alloc_fire_b)
                          - rob_idx_t'(cmt_we_a)     - rob_idx_t'(cmt_we_b);

        if (cdb_ok_a) done_d[cdb_idx_a] = 1'b1;
        if (cdb_ok_b) done_d[cdb_idx_b] = 1'b1;

        if (cmt_we_a) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_nx;
        end
        if (cmt_we_b) begin
            busy_d[head_nx] = 1'b0;
            done_d[head_nx] = 1'b0;
            head_d          = rob_next(head_nx);
        end

        if (alloc_fire_a) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            tail_d         = alloc_idx_b;
        end
        if (alloc_fire_b) begin
            busy_d[alloc_idx_b] = 1'b1;
            done_d[alloc_idx_b] = 1'b0;
            tail_d              = rob_next(alloc_idx_b);
        end

        if (flush) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = rob_idx_t'(1);
            tail_d  = rob_idx_t'(1);
            count_d = '0;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            busy_q  <= '0;
            done_q  <= '0;
            head_q  <= rob_idx_t'(1);
            tail_q  <= rob_idx_t'(1);
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage: destination on allocate, result on writeback; port B written last so it wins.
    always_ff @(posedge clk) begin
        // NOTE: payload arrays are not reset; busy/done qualify every read of them.
        if (alloc_fire_a) dest_q[tail_q]      <= alloc_dest_a;
        if (alloc_fire_b) dest_q[alloc_idx_b] <= alloc_dest_b;
        if (cdb_ok_a)     data_q[cdb_idx_a]   <= cdb_data_a;
        if (cdb_ok_b)     data_q[cdb_idx_b]   <= cdb_data_b;
    end

    // Operand lookup A: same-cycle CDB (B before A) beats the stored result.
    always_comb begin
        qry_hit_a  = 1'b0;
        qry_data_a = '0;
        if ((qry_idx_a != NULL_IDX) && busy_q[qry_idx_a]) begin
            if (cdb_valid_b && (cdb_idx_b == qry_idx_a)) begin
                qry_hit_a  = 1'b1;
                qry_data_a = cdb_data_b;
            end else if (cdb_valid_a && (cdb_idx_a == qry_idx_a)) begin
                qry_hit_a  = 1'b1;
                qry_data_a = cdb_data_a;
            end else if (done_q[qry_idx_a]) begin
                qry_hit_a  = 1'b1;
                qry_data_a = data_q[qry_idx_a];
            end
        end
    end

    // Operand lookup B: same priority order as port A.
    always_comb begin
        qry_hit_b  = 1'b0;
        qry_data_b = '0;
        if ((qry_idx_b != NULL_IDX) && busy_q[qry_idx_b]) begin
            if (cdb_valid_b && (cdb_idx_b == qry_idx_b)) begin
                qry_hit_b  = 1'b1;
                qry_data_b = cdb_data_b;
            end else if (cdb_valid_a && (cdb_idx_a == qry_idx_b)) begin
                qry_hit_b  = 1'b1;
                qry_data_b = cdb_data_a;
            end else if (done_q[qry_idx_b]) begin
                qry_hit_b  = 1'b1;
                qry_data_b = data_q[qry_idx_b];
            end
        end
    end

endmodule

// File: tb/tb_float_reorder_buffer.sv
// Directed bench for float_reorder_buffer with an in-order commit scoreboard.
module tb_float_reorder_buffer;
    import float_rob_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              alloc_req_a, alloc_req_b;
    logic [REG_W-1:0]  alloc_dest_a, alloc_dest_b;
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_idx_a, alloc_idx_b;
    logic              cdb_valid_a, cdb_valid_b;
    logic [IDX_W-1:0]  cdb_idx_a, cdb_idx_b;
    logic [DATA_W-1:0] cdb_data_a, cdb_data_b;
    logic [IDX_W-1:0]  qry_idx_a, qry_idx_b;
    logic              qry_hit_a, qry_hit_b;
    logic [DATA_W-1:0] qry_data_a, qry_data_b;
    logic              cmt_we_a, cmt_we_b;
    logic [REG_W-1:0]  cmt_wn_a, cmt_wn_b;
    logic [IDX_W-1:0]  cmt_idx_a, cmt_idx_b;
    logic [DATA_W-1:0] cmt_data_a, cmt_data_b;
    logic [IDX_W-1:0]  count;
    logic              empty;

    always #5 clk = ~clk;

    float_reorder_buffer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_req_a(alloc_req_a), .alloc_req_b(alloc_req_b),
        .alloc_dest_a(alloc_dest_a), .alloc_dest_b(alloc_dest_b),
        .alloc_ready(alloc_ready), .alloc_idx_a(alloc_idx_a), .alloc_idx_b(alloc_idx_b),
        .cdb_valid_a(cdb_valid_a), .cdb_valid_b(cdb_valid_b),
        .cdb_idx_a(cdb_idx_a), .cdb_idx_b(cdb_idx_b),
        .cdb_data_a(cdb_data_a), .cdb_data_b(cdb_data_b),
        .qry_idx_a(qry_idx_a), .qry_idx_b(qry_idx_b),
        .qry_hit_a(qry_hit_a), .qry_hit_b(qry_hit_b),
        .qry_data_a(qry_data_a), .qry_data_b(qry_data_b),
        .cmt_we_a(cmt_we_a), .cmt_we_b(cmt_we_b),
        .cmt_wn_a(cmt_wn_a), .cmt_wn_b(cmt_wn_b),
        .cmt_idx_a(cmt_idx_a), .cmt_idx_b(cmt_idx_b),
        .cmt_data_a(cmt_data_a), .cmt_data_b(cmt_data_b),
        .count(count), .empty(empty)
    );

    // Scoreboard: allocated entries in program order; results recorded as they are broadcast.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [REG_W-1:0] dest;
    } sb_entry_t;

    sb_entry_t         sb [$];
    logic              mbusy [16];
    logic              mdone [16];
    logic [DATA_W-1:0] mdata [16];
    logic [IDX_W-1:0]  exp_tail;

    int n_cmp  = 0;
    int n_fail = 0;

    int drain_order [14] = '{7, 8, 9, 10, 11, 12, 13, 14, 15, 1, 2, 3, 4, 5};

    function automatic logic [IDX_W-1:0] tb_next(input logic [IDX_W-1:0] i);
        return (i == 4'd15) ? 4'd1 : i + 4'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < 16; i++) begin
            mbusy[i] = 1'b0;
            mdone[i] = 1'b0;
            mdata[i] = '0;
        end
        exp_tail = 4'd1;
    endtask

    task automatic clear_inputs();
        flush        = 1'b0;
        alloc_req_a  = 1'b0;
        alloc_req_b  = 1'b0;
        alloc_dest_a = '0;
        alloc_dest_b = '0;
        cdb_valid_a  = 1'b0;
        cdb_valid_b  = 1'b0;
        cdb_idx_a    = '0;
        cdb_idx_b    = '0;
        cdb_data_a   = '0;
        cdb_data_b   = '0;
        qry_idx_a    = '0;
        qry_idx_b    = '0;
    endtask

    // One clock: check outputs against the scoreboard at the falling edge, then
    // advance the scoreboard with what the rising edge should have done.
    task automatic tick();
        logic ew_a, ew_b, ready;
        @(negedge clk);
        ew_a  = !flush && (sb.size() > 0) && mdone[sb[0].idx];
        ew_b  = ew_a && (sb.size() > 1) && mdone[sb[1].idx];
        ready = (sb.size() <= 13);
        check("cmt_we_a",    32'(cmt_we_a),    32'(ew_a));
        check("cmt_we_b",    32'(cmt_we_b),    32'(ew_b));
        check("count",       32'(count),       32'(sb.size()));
        check("empty",       32'(empty),       32'(sb.size() == 0));
        check("alloc_ready", 32'(alloc_ready), 32'(ready));
        check("alloc_idx_a", 32'(alloc_idx_a), 32'(exp_tail));
        check("alloc_idx_b", 32'(alloc_idx_b), 32'(tb_next(exp_tail)));
        if (ew_a) begin
            check("cmt_idx_a",  32'(cmt_idx_a), 32'(sb[0].idx));
            check("cmt_wn_a",   32'(cmt_wn_a),  32'(sb[0].dest));
            check("cmt_data_a", cmt_data_a,     mdata[sb[0].idx]);
        end
        if (ew_b) begin
            check("cmt_idx_b",  32'(cmt_idx_b), 32'(sb[1].idx));
            check("cmt_wn_b",   32'(cmt_wn_b),  32'(sb[1].dest));
            check("cmt_data_b", cmt_data_b,     mdata[sb[1].idx]);
        end
        @(posedge clk);
        if (flush) begin
            model_reset();
        end else begin
            if (cdb_valid_a && cdb_idx_a != 4'd0 && mbusy[cdb_idx_a]) begin
                mdone[cdb_idx_a] = 1'b1;
                mdata[cdb_idx_a] = cdb_data_a;
            end
            if (cdb_valid_b && cdb_idx_b != 4'd0 && mbusy[cdb_idx_b]) begin
                mdone[cdb_idx_b] = 1'b1;
                mdata[cdb_idx_b] = cdb_data_b;
            end
            for (int n = 0; n < 2; n++) begin
                if ((n == 0 && ew_a) || (n == 1 && ew_b)) begin
                    mbusy[sb[0].idx] = 1'b0;
                    mdone[sb[0].idx] = 1'b0;
                    void'(sb.pop_front());
                end
            end
            if (ready && alloc_req_a) begin
                sb.push_back(sb_entry_t'{idx: exp_tail, dest: alloc_dest_a});
                mbusy[exp_tail] = 1'b1;
                mdone[exp_tail] = 1'b0;
                exp_tail = tb_next(exp_tail);
                if (alloc_req_b) begin
                    sb.push_back(sb_entry_t'{idx: exp_tail, dest: alloc_dest_b});
                    mbusy[exp_tail] = 1'b1;
                    mdone[exp_tail] = 1'b0;
                    exp_tail = tb_next(exp_tail);
                end
            end
        end
        #1;
    endtask

    task automatic alloc2(input logic [REG_W-1:0] da, input logic [REG_W-1:0] db);
        alloc_req_a  = 1'b1;
        alloc_req_b  = 1'b1;
        alloc_dest_a = da;
        alloc_dest_b = db;
        tick();
        clear_inputs();
    endtask

    task automatic alloc1(input logic [REG_W-1:0] da);
        alloc_req_a  = 1'b1;
        alloc_dest_a = da;
        tick();
        clear_inputs();
    endtask

    task automatic cdb(input logic va, input logic [IDX_W-1:0] ia, input logic [DATA_W-1:0] da,
                       input logic vb, input logic [IDX_W-1:0] ib, input logic [DATA_W-1:0] db);
        cdb_valid_a = va;
        cdb_idx_a   = ia;
        cdb_data_a  = da;
        cdb_valid_b = vb;
        cdb_idx_b   = ib;
        cdb_data_b  = db;
        tick();
        clear_inputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        qry_idx_a = 4'd1;
        #12;
        check("rst_count",   32'(count),       32'd0);
        check("rst_empty",   32'(empty),       32'd1);
        check("rst_ready",   32'(alloc_ready), 32'd1);
        check("rst_idx_a",   32'(alloc_idx_a), 32'd1);
        check("rst_idx_b",   32'(alloc_idx_b), 32'd2);
        check("rst_we_a",    32'(cmt_we_a),    32'd0);
        check("rst_we_b",    32'(cmt_we_b),    32'd0);
        check("rst_qry_hit", 32'(qry_hit_a),   32'd0);
        check("rst_qry_dat", qry_data_a,       32'd0);
        qry_idx_a = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill with dests f1..f14: indexes 1..14, then a refused request
        for (int k = 0; k < 7; k++) alloc2(5'(2 * k + 1), 5'(2 * k + 2));
        check("fill_count", 32'(count), 32'd14);
        alloc2(5'd20, 5'd21);
        check("full_ready", 32'(alloc_ready), 32'd0);

        // Out-of-order completion: idx 2 then idx 1, then a paired retire
        cdb(1'b1, 4'd2, 32'h4000_0002, 1'b0, '0, '0);
        cdb(1'b1, 4'd1, 32'h4000_0001, 1'b0, '0, '0);
        idle(1);
        check("pair_retire_count", 32'(count), 32'd12);

        // Allocation wraps 15 -> 1
        alloc2(5'd15, 5'd16);
        cdb(1'b1, 4'd3, 32'h4000_0003, 1'b1, 4'd4, 32'h4000_0004);
        idle(1);

        // Same-cycle CDB bypass on query; no commit before the edge
        cdb_valid_a = 1'b1;
        cdb_idx_a   = 4'd5;
        cdb_data_a  = 32'h3F80_0000;
        qry_idx_a   = 4'd5;
        qry_idx_b   = 4'd6;
        #2;
        check("bypass_hit",   32'(qry_hit_a), 32'd1);
        check("bypass_data",  qry_data_a,     32'h3F80_0000);
        check("pending_hit",  32'(qry_hit_b), 32'd0);
        check("pending_data", qry_data_b,     32'd0);
        check("bypass_no_we", 32'(cmt_we_a),  32'd0);
        tick();
        clear_inputs();

        // Stored-result lookup while idx 5 retires
        cdb_valid_a = 1'b1;
        cdb_idx_a   = 4'd6;
        cdb_data_a  = 32'h4000_0006;
        qry_idx_b   = 4'd5;
        #2;
        check("stored_hit",  32'(qry_hit_b), 32'd1);
        check("stored_data", qry_data_b,     32'h3F80_0000);
        tick();
        clear_inputs();
        idle(1);

        // Refill after the wrap: indexes 2..5
        alloc2(5'd17, 5'd18);
        alloc2(5'd19, 5'd20);
        check("refill_count", 32'(count), 32'd14);

        // Drain: both ports hit idx 7 (B wins), then the rest in pairs
        cdb(1'b1, 4'd7, 32'hAAAA_AAAA, 1'b1, 4'd7, 32'h4000_0007);
        for (int i = 1; i < 14; i += 2) begin
            cdb(1'b1, 4'(drain_order[i]), 32'h5000_0000 | 32'(drain_order[i]),
                (i + 1 < 14), 4'((i + 1 < 14) ? drain_order[i + 1] : 0),
                32'h5100_0000 | 32'((i + 1 < 14) ? drain_order[i + 1] : 0));
        end
        idle(8);
        check("drain_count", 32'(count), 32'd0);

        // Stray broadcasts: idle idx 9 and null idx 0
        cdb_valid_a = 1'b1;
        cdb_idx_a   = 4'd9;
        cdb_data_a  = 32'hDEAD_BEEF;
        cdb_valid_b = 1'b1;
        cdb_idx_b   = 4'd0;
        cdb_data_b  = 32'hCAFE_F00D;
        qry_idx_a   = 4'd9;
        qry_idx_b   = 4'd0;
        #2;
        check("stray_hit_a",  32'(qry_hit_a), 32'd0);
        check("stray_data_a", qry_data_a,     32'd0);
        check("null_hit_b",   32'(qry_hit_b), 32'd0);
        check("null_data_b",  qry_data_b,     32'd0);
        tick();
        clear_inputs();
        idle(2);

        // Flush with 6 pending entries while the head pair is ready to retire
        alloc2(5'd1, 5'd2);
        alloc2(5'd3, 5'd4);
        alloc2(5'd5, 5'd6);
        cdb(1'b1, 4'd6, 32'h6000_0006, 1'b1, 4'd7, 32'h6000_0007);
        flush       = 1'b1;
        alloc_req_a = 1'b1;
        cdb_valid_a = 1'b1;
        cdb_idx_a   = 4'd8;
        #2;
        check("flush_we_a", 32'(cmt_we_a), 32'd0);
        tick();
        clear_inputs();
        idle(1);
        alloc1(5'd7);
        check("post_flush_count", 32'(count), 32'd1);

        // Asynchronous reset mid-operation
        alloc2(5'd8, 5'd9);
        cdb(1'b1, 4'd1, 32'h7000_0001, 1'b0, '0, '0);
        rst_n = 1'b0;
        #2;
        check("arst_count", 32'(count),       32'd0);
        check("arst_empty", 32'(empty),       32'd1);
        check("arst_idx_a", 32'(alloc_idx_a), 32'd1);
        check("arst_idx_b", 32'(alloc_idx_b), 32'd2);
        check("arst_we_a",  32'(cmt_we_a),    32'd0);
        check("arst_we_b",  32'(cmt_we_b),    32'd0);
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        alloc1(5'd9);
        cdb(1'b1, 4'd1, 32'h7100_0001, 1'b0, '0, '0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
